// File: rtl/pipe_pkg.sv
// Shared pipeline control-word bit indices, instruction field positions and FSM types.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package pipe_pkg;

    // Control-word bits already decoded by EX
    localparam int CS_IS_BEQ  = 2;
    localparam int CS_IS_BGT  = 3;
    localparam int CS_IS_IMM  = 4;
    localparam int CS_IS_UBR  = 7;

    // Control-word bits used for hazard detection and sequencing
    localparam int CS_IS_LD   = 8;
    localparam int CS_IS_ST   = 9;
    localparam int CS_IS_WB   = 10;
    localparam int CS_IS_CALL = 11;
    localparam int CS_IS_RET  = 12;
    localparam int CS_IS_MC   = 13;

    // Return-address register: implicit destination of call and source of ret
    localparam int RA_IDX     = 15;

    // Register field LSB positions inside a 32-bit instruction
    localparam int RD_LSB     = 22;
    localparam int RS1_LSB    = 18;
    localparam int RS2_LSB    = 14;

    // Multi-cycle countdown width; enough for the largest legal MC_LAT of 15
    localparam int MC_W       = 4;

    typedef enum logic {
        RUN     = 1'b0,
        MC_BUSY = 1'b1
    } mc_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts cycles with inc=1 and sticks at all-ones.
// Latency: count reflects inc one cycle later.
// Backpressure: none.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    // Increment until all-ones, then hold so the count never wraps
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller: forwarding selects, load-use stalls, branch flushes, multi-cycle EX ops.
// Latency: stall/flush/bubble are combinational; forwarding selects register into EX on advance.
// Backpressure: stalls IF/OF for one cycle on load-use and IF/OF/EX for MC_LAT-1 cycles on a multi-cycle op.
module pipeline_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MC_LAT = 4,
    parameter int CNT_W  = 16,
    parameter int REG_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      inst_of,
    input  logic [21:0]      cs_of,
    input  logic [31:0]      inst_ex,
    input  logic [21:0]      cs_ex,
    input  logic [31:0]      inst_ma,
    input  logic [21:0]      cs_ma,
    input  logic             isBranchTaken,
    output logic             forwarding_signal1_for_MA_EX,
    output logic             forwarding_signal1_for_RW_EX,
    output logic             forwarding_signal2_for_MA_EX,
    output logic             forwarding_signal2_for_RW_EX,
    output logic             stall_if,
    output logic             stall_of,
    output logic             stall_ex,
    output logic             bubble_ex,
    output logic             bubble_ma,
    output logic             flush_if,
    output logic             ex_busy,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [REG_W-1:0] RA      = REG_W'(RA_IDX);
    localparam logic [MC_W-1:0]  MC_INIT = MC_W'(MC_LAT - 2);

    mc_state_e       state, state_nxt;
    logic [MC_W-1:0] mc_cnt, mc_cnt_nxt;

    logic [REG_W-1:0] src1, src2, dst_ex, dst_ma;
    logic             src2_used;
    logic             ex_wr_src1, ex_wr_src2, ma_wr_src1, ma_wr_src2;
    logic             load_use, fwd1_ma, fwd2_ma;
    logic             unused_bits;

    // Source registers read in OF; ret reads the return-address register, store reads rd as data
    always_comb begin
        src1      = cs_of[CS_IS_RET] ? RA : inst_of[RS1_LSB +: REG_W];
        src2      = cs_of[CS_IS_ST]  ? inst_of[RD_LSB +: REG_W] : inst_of[RS2_LSB +: REG_W];
        src2_used = cs_of[CS_IS_ST] || !cs_of[CS_IS_IMM];
        dst_ex    = cs_ex[CS_IS_CALL] ? RA : inst_ex[RD_LSB +: REG_W];
        dst_ma    = cs_ma[CS_IS_CALL] ? RA : inst_ma[RD_LSB +: REG_W];
    end

    // Which later stages write the registers OF is about to read
    always_comb begin
        ex_wr_src1 = cs_ex[CS_IS_WB] && (dst_ex == src1);
        ex_wr_src2 = cs_ex[CS_IS_WB] && (dst_ex == src2) && src2_used;
        ma_wr_src1 = cs_ma[CS_IS_WB] && (dst_ma == src1);
        ma_wr_src2 = cs_ma[CS_IS_WB] && (dst_ma == src2) && src2_used;
        load_use   = cs_ex[CS_IS_LD] && (ex_wr_src1 || ex_wr_src2);
        // A load's value is not ready in MA's ALU slot, so it is never forwarded from MA
        fwd1_ma    = ex_wr_src1 && !cs_ex[CS_IS_LD];
        fwd2_ma    = ex_wr_src2 && !cs_ex[CS_IS_LD];
    end

    // Multi-cycle state and countdown; reset aborts any op in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= RUN;
            mc_cnt <= '0;
        end else begin
            state  <= state_nxt;
            mc_cnt <= mc_cnt_nxt;
        end
    end

    // Enter MC_BUSY when a multi-cycle op reaches EX; return to RUN the cycle after the count hits zero
    always_comb begin
        state_nxt  = state;
        mc_cnt_nxt = mc_cnt;
        case (state)
            RUN: begin
                if (cs_ex[CS_IS_MC]) begin
                    state_nxt  = MC_BUSY;
                    mc_cnt_nxt = MC_INIT;
                end
            end
            MC_BUSY: begin
                if (mc_cnt == '0) begin
                    state_nxt = RUN;
                end else begin
                    mc_cnt_nxt = mc_cnt - 1'b1;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    // Prioritised pipeline controls: branch flush, then multi-cycle hold, then load-use stall
    always_comb begin
        ex_busy   = 1'b0;
        stall_if  = 1'b0;
        stall_of  = 1'b0;
        stall_ex  = 1'b0;
        bubble_ex = 1'b0;
        bubble_ma = 1'b0;
        flush_if  = 1'b0;
        if (!rst) begin
            ex_busy = ((state == RUN) && cs_ex[CS_IS_MC]) ||
                      ((state == MC_BUSY) && (mc_cnt != '0));
            if (isBranchTaken && (state == RUN) && !ex_busy) begin
                flush_if  = 1'b1;
                bubble_ex = 1'b1;
            end else if (ex_busy) begin
                stall_if  = 1'b1;
                stall_of  = 1'b1;
                stall_ex  = 1'b1;
                bubble_ma = 1'b1;
            end else if (load_use) begin
                stall_if  = 1'b1;
                stall_of  = 1'b1;
                bubble_ex = 1'b1;
            end
        end
    end

    // Forwarding selects travel with the OF/EX register: cleared on bubble, held on stall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            forwarding_signal1_for_MA_EX <= 1'b0;
            forwarding_signal1_for_RW_EX <= 1'b0;
            forwarding_signal2_for_MA_EX <= 1'b0;
            forwarding_signal2_for_RW_EX <= 1'b0;
        end else if (bubble_ex) begin
            forwarding_signal1_for_MA_EX <= 1'b0;
            forwarding_signal1_for_RW_EX <= 1'b0;
            forwarding_signal2_for_MA_EX <= 1'b0;
            forwarding_signal2_for_RW_EX <= 1'b0;
        end else if (!stall_ex) begin
            forwarding_signal1_for_MA_EX <= fwd1_ma;
            forwarding_signal1_for_RW_EX <= ma_wr_src1 && !fwd1_ma;
            forwarding_signal2_for_MA_EX <= fwd2_ma;
            forwarding_signal2_for_RW_EX <= ma_wr_src2 && !fwd2_ma;
        end
    end

    // Instruction and control bits this controller does not decode
    assign unused_bits = ^{inst_of, cs_of, inst_ex, cs_ex, inst_ma, cs_ma};

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (stall_if),
        .cnt (stall_cycles)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (flush_if),
        .cnt (flush_count)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with hand-computed expectations.
// Runs with MC_LAT=4 and CNT_W=2 so counter saturation is reachable.
// Inputs driven 1 time unit after the rising edge, outputs checked 2 units later.
module tb_pipeline_hazard_ctrl;
    import pipe_pkg::*;

    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [31:0]      inst_of, inst_ex, inst_ma;
    logic [21:0]      cs_of, cs_ex, cs_ma;
    logic             isBranchTaken;
    logic             f1_ma, f1_rw, f2_ma, f2_rw;
    logic             stall_if, stall_of, stall_ex, bubble_ex, bubble_ma, flush_if, ex_busy;
    logic [CNT_W-1:0] stall_cycles, flush_count;

    int n_checks = 0;
    int n_fail   = 0;

    pipeline_hazard_ctrl #(.MC_LAT(4), .CNT_W(CNT_W), .REG_W(4)) dut (
        .clk                          (clk),
        .rst                          (rst),
        .inst_of                      (inst_of),
        .cs_of                        (cs_of),
        .inst_ex                      (inst_ex),
        .cs_ex                        (cs_ex),
        .inst_ma                      (inst_ma),
        .cs_ma                        (cs_ma),
        .isBranchTaken                (isBranchTaken),
        .forwarding_signal1_for_MA_EX (f1_ma),
        .forwarding_signal1_for_RW_EX (f1_rw),
        .forwarding_signal2_for_MA_EX (f2_ma),
        .forwarding_signal2_for_RW_EX (f2_rw),
        .stall_if                     (stall_if),
        .stall_of                     (stall_of),
        .stall_ex                     (stall_ex),
        .bubble_ex                    (bubble_ex),
        .bubble_ma                    (bubble_ma),
        .flush_if                     (flush_if),
        .ex_busy                      (ex_busy),
        .stall_cycles                 (stall_cycles),
        .flush_count                  (flush_count)
    );

    always #5 clk = ~clk;

    // Grouped views: fwd = {f1_ma, f1_rw, f2_ma, f2_rw}; ctl = {stall_if, stall_of, stall_ex, bubble_ex, bubble_ma, flush_if}
    logic [3:0]  fwd;
    logic [5:0]  ctl;
    logic [14:0] all_out;
    assign fwd     = {f1_ma, f1_rw, f2_ma, f2_rw};
    assign ctl     = {stall_if, stall_of, stall_ex, bubble_ex, bubble_ma, flush_if};
    assign all_out = {fwd, ctl, ex_busy, stall_cycles, flush_count};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(input int rd, input int rs1, input int rs2);
        logic [31:0] r;
        r        = '0;
        r[25:22] = rd[3:0];
        r[21:18] = rs1[3:0];
        r[17:14] = rs2[3:0];
        return r;
    endfunction

    function automatic logic [21:0] bit_cs(input int idx);
        logic [21:0] c;
        c      = '0;
        c[idx] = 1'b1;
        return c;
    endfunction

    task automatic nops();
        inst_of = '0; cs_of = '0;
        inst_ex = '0; cs_ex = '0;
        inst_ma = '0; cs_ma = '0;
        isBranchTaken = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic pulse_reset(input string tag);
        nops();
        rst = 1'b1;
        #1;
        check_eq(tag, 32'(all_out), 32'd0);
        next_cycle();
        rst = 1'b0;
    endtask

    logic [21:0] WB, LD, ST, IMM, CALL, RET, MC;

    initial begin
        WB = bit_cs(CS_IS_WB);  LD  = bit_cs(CS_IS_LD);   ST  = bit_cs(CS_IS_ST);
        IMM = bit_cs(CS_IS_IMM); CALL = bit_cs(CS_IS_CALL); RET = bit_cs(CS_IS_RET);
        MC = bit_cs(CS_IS_MC);

        rst = 1'b1;
        nops();
        #3;
        check_eq("reset_outputs", 32'(all_out), 32'd0);
        next_cycle();
        rst = 1'b0;

        // add r1 in EX, add r2,r1,r3 in OF -> forward A from MA next cycle
        inst_ex = mk(1, 0, 0); cs_ex = WB;
        inst_of = mk(2, 1, 3); cs_of = '0;
        settle();
        check_eq("alu_dep_no_stall", 32'(ctl), 32'd0);
        next_cycle();
        nops();
        settle();
        check_eq("alu_dep_fwd", 32'(fwd), 32'b1000);
        next_cycle();

        // ld r1 in EX, add r2,r1,r1 in OF -> one-cycle load-use stall
        inst_ex = mk(1, 0, 0); cs_ex = LD | WB;
        inst_of = mk(2, 1, 1); cs_of = '0;
        settle();
        check_eq("load_use_ctl", 32'(ctl), 32'b110100);
        next_cycle();
        inst_ex = '0; cs_ex = '0;
        inst_ma = mk(1, 0, 0); cs_ma = LD | WB;
        settle();
        check_eq("load_use_released", 32'(ctl), 32'd0);
        check_eq("load_use_fwd_cleared", 32'(fwd), 32'd0);
        check_eq("load_use_stall_cnt", 32'(stall_cycles), 32'd1);
        next_cycle();

        // mul in EX: busy 3 cycles, EX occupied 4, selects held from the previous advance
        inst_ex = mk(7, 8, 9); cs_ex = MC | WB;
        inst_ma = '0; cs_ma = '0;
        for (int i = 0; i < 4; i++) begin
            settle();
            check_eq($sformatf("mul_busy_%0d", i), 32'({ex_busy, stall_ex, bubble_ma}),
                     (i < 3) ? 32'b111 : 32'b000);
            check_eq($sformatf("mul_fwd_hold_%0d", i), 32'(fwd), 32'b0101);
            next_cycle();
        end
        inst_ex = '0; cs_ex = '0;
        settle();
        check_eq("mul_done_busy", 32'(ex_busy), 32'd0);
        check_eq("mul_done_fwd", 32'(fwd), 32'd0);
        check_eq("stall_cnt_saturated", 32'(stall_cycles), 32'd3);
        next_cycle();

        pulse_reset("reset_pulse_outputs");

        // Taken branch together with a load-use hazard: flush wins
        inst_ex = mk(1, 0, 0); cs_ex = LD | WB;
        inst_of = mk(2, 1, 1); cs_of = '0;
        isBranchTaken = 1'b1;
        settle();
        check_eq("branch_over_loaduse", 32'(ctl), 32'b000101);
        next_cycle();
        nops();
        settle();
        check_eq("branch_flush_cnt", 32'(flush_count), 32'd1);
        check_eq("branch_stall_cnt", 32'(stall_cycles), 32'd0);
        next_cycle();

        // r5 written in EX and MA, st r5 in OF -> B from MA only (store data ignores imm)
        inst_ex = mk(5, 0, 0); cs_ex = WB;
        inst_ma = mk(5, 0, 0); cs_ma = WB;
        inst_of = mk(5, 2, 0); cs_of = ST | IMM;
        next_cycle();
        // Immediate ALU op: rs2 matches EX but is ignored
        inst_ex = mk(6, 0, 0); cs_ex = WB;
        inst_ma = '0; cs_ma = '0;
        inst_of = mk(2, 0, 6); cs_of = IMM;
        settle();
        check_eq("store_fwd_ex_beats_ma", 32'(fwd), 32'b0010);
        next_cycle();
        // call in EX writes r15; ret in OF reads r15
        inst_ex = mk(3, 0, 0); cs_ex = WB | CALL;
        inst_of = mk(0, 2, 3); cs_of = RET | IMM;
        settle();
        check_eq("imm_ignores_rs2", 32'(fwd), 32'd0);
        next_cycle();
        nops();
        settle();
        check_eq("call_ret_fwd", 32'(fwd), 32'b1000);
        next_cycle();

        // Reset in the middle of a multi-cycle op at mc_cnt=1
        inst_ex = mk(7, 8, 9); cs_ex = MC | WB;
        next_cycle();
        next_cycle();
        settle();
        check_eq("mc_before_reset", 32'(ex_busy), 32'd1);
        rst = 1'b1;
        #1;
        check_eq("mc_async_reset", 32'(all_out), 32'd0);
        next_cycle();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            settle();
            check_eq($sformatf("mul_after_reset_%0d", i), 32'(ex_busy), (i < 3) ? 32'd1 : 32'd0);
            next_cycle();
        end
        nops();
        settle();
        check_eq("stall_cnt_after_mul", 32'(stall_cycles), 32'd3);

        // One more load-use stall: counter sticks at 3
        inst_ex = mk(4, 0, 0); cs_ex = LD | WB;
        inst_of = mk(2, 4, 0); cs_of = '0;
        settle();
        check_eq("loaduse2_ctl", 32'(ctl), 32'b110100);
        next_cycle();
        nops();
        settle();
        check_eq("stall_cnt_no_wrap", 32'(stall_cycles), 32'd3);

        // Four taken branches: flush count sticks at 3
        for (int i = 0; i < 4; i++) begin
            isBranchTaken = 1'b1;
            next_cycle();
        end
        isBranchTaken = 1'b0;
        settle();
        check_eq("flush_cnt_no_wrap", 32'(flush_count), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central hazard and sequencing controller for the 5-stage pipeline (IF, OF, EX, MA, RW).
- Computes the four EX forwarding selects and registers them into EX alongside the OF→EX pipeline register.
- Generates load-use stalls, branch flushes and multi-cycle EX-op sequencing; keeps saturating stall and flush performance counters.

Parameters:
- MC_LAT, 4, total EX occupancy in cycles of a multi-cycle op (mul/div/mod); legal range 2..15
- CNT_W, 16, width of the performance counters
- REG_W, 4, register index width

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-high reset
- inst_of  in  32  instruction in OF
- cs_of  in  22  control signals in OF
- inst_ex  in  32  instruction in EX
- cs_ex  in  22  control signals in EX
- inst_ma  in  32  instruction in MA
- cs_ma  in  22  control signals in MA
- isBranchTaken  in  1  branch resolution from EX
- forwarding_signal1_for_MA_EX  out  1  registered; A ← MA ALU result
- forwarding_signal1_for_RW_EX  out  1  registered; A ← RW data
- forwarding_signal2_for_MA_EX  out  1  registered; B ← MA ALU result
- forwarding_signal2_for_RW_EX  out  1  registered; B/op2 ← RW data
- stall_if  out  1  hold PC
- stall_of  out  1  hold IF/OF register
- stall_ex  out  1  hold OF/EX register and EX inputs
- bubble_ex  out  1  load NOP into OF/EX register
- bubble_ma  out  1  load NOP into EX/MA register
- flush_if  out  1  squash IF/OF register
- ex_busy  out  1  multi-cycle op in progress
- stall_cycles  out  CNT_W  saturating count of cycles with stall_if=1
- flush_count  out  CNT_W  saturating count of taken-branch flushes

Behaviour:
- Register fields: rd = inst[25:22], rs1 = inst[21:18], rs2 = inst[17:14].
- OF sources:
  - src1 = rs1, or 15 when cs_of[CS_IS_RET].
  - src2 = rd when cs_of[CS_IS_ST], else rs2.
  - src2 is ignored when cs_of[4] (isImmediate) is set and the op is not a store.
- A stage "writes r" when its cs[CS_IS_WB]=1 and its destination equals r. Destination is rd, or 15 when cs[CS_IS_CALL].
- FSM states: RUN, MC_BUSY. Reset → RUN with mc_cnt=0.
- RUN with cs_ex[CS_IS_MC]=1 → MC_BUSY, mc_cnt=MC_LAT-2.
- MC_BUSY: decrement mc_cnt each cycle; leave to RUN in the cycle after mc_cnt reaches 0.
- Total EX occupancy is MC_LAT cycles.
- ex_busy = cs_ex[CS_IS_MC] in RUN, or state==MC_BUSY with mc_cnt≠0.
- Combinational priority, top wins:
  1. isBranchTaken in RUN → flush_if=1, bubble_ex=1, no stalls.
  2. ex_busy → stall_if=stall_of=stall_ex=1, bubble_ma=1.
  3. Load-use: cs_ex[CS_IS_LD], EX writes src1 or src2 → stall_if=stall_of=1, bubble_ex=1, one cycle.
- isBranchTaken is ignored while ex_busy. Multi-cycle ops never branch.
- Forwarding selects are registered, updated only on advance:
  - Advance = !stall_ex and !bubble_ex.
  - On advance, sigN_MA = EX writes srcN and !cs_ex[CS_IS_LD].
  - On advance, sigN_RW = MA writes srcN and !sigN_MA (EX beats MA).
  - On bubble_ex: all four cleared.
  - On stall_ex: held.
- Counters: stall_cycles increments on every stall_if cycle; flush_count increments on every flush_if cycle. Both saturate at all-ones and never wrap.
- Reset values: all outputs 0, counters 0, FSM RUN. Reset mid-MC_BUSY aborts the op immediately.

Decomposition:
- Shared package pipe_pkg holds the control-signal bit indices already used by EX: CS_IS_BEQ=2, CS_IS_BGT=3, CS_IS_IMM=4, CS_IS_UBR=7.
- It adds CS_IS_LD=8, CS_IS_ST=9, CS_IS_WB=10, CS_IS_CALL=11, CS_IS_RET=12, CS_IS_MC=13, RA_IDX=15, and the rd/rs1/rs2 field LSB constants.
- One sub-module: sat_counter (CNT_W, inc, rst), instantiated twice.

Test Plan:
- Back-to-back add r1 then add r2,r1,r3 → next cycle forwarding_signal1_for_MA_EX=1, all others 0, no stall.
- ld r1 then add r2,r1,r1 → one cycle of stall_if=stall_of=bubble_ex=1. Then forwarding_signal1_for_RW_EX=1 and forwarding_signal2_for_RW_EX=1. stall_cycles=1.
- mul in EX with MC_LAT=4 → ex_busy, stall_ex and bubble_ma high for exactly 3 cycles. EX holds 4 cycles. Forwarding selects held unchanged throughout.
- isBranchTaken=1 in the same cycle as a load-use hazard → flush_if=1, bubble_ex=1, stall_if=0. flush_count=1, stall_cycles unchanged.
- r5 written by both EX and MA, OF st r5 → forwarding_signal2_for_MA_EX=1, forwarding_signal2_for_RW_EX=0.
- rst asserted during MC_BUSY at mc_cnt=1 → all outputs 0 asynchronously, FSM RUN. After release, a new mul lasts a full MC_LAT cycles. Counters with CNT_W=2 stick at 3.
